// File: rtl/water_flow_pkg.sv
// Shared encodings for the water flow supervisor: mode values, FSM states and fault codes.
package water_flow_pkg;

    localparam logic [1:0] ModeIdle  = 2'b00;
    localparam logic [1:0] ModeFill  = 2'b01;
    localparam logic [1:0] ModeDrain = 2'b10;
    localparam logic [1:0] ModeHold  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMonitor,
        StFault
    } state_e;

    localparam logic [2:0] ErrNone     = 3'b000;
    localparam logic [2:0] ErrNoRise   = 3'b001;
    localparam logic [2:0] ErrNoFall   = 3'b010;
    localparam logic [2:0] ErrOverflow = 3'b011;
    localparam logic [2:0] ErrLeak     = 3'b100;
    localparam logic [2:0] ErrDrift    = 3'b101;

    localparam int unsigned FaultCountW = 8;

endpackage

// File: rtl/wfs_stall_timer.sv
// Saturating no-progress counter; expired is high once TIME_LIMIT-1 idle cycles have elapsed.
module wfs_stall_timer #(
    parameter int unsigned TIME_LIMIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CntW = (TIME_LIMIT > 1) ? $clog2(TIME_LIMIT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIME_LIMIT - 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != Last)) begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign expired = (count_q == Last);

endmodule

// File: rtl/water_flow_supervisor.sv
// Tank fill/drain/hold supervisor raising sticky, coded faults on stalls, overflow, leaks and drift.
// Define WFS_FAULT_COUNT_EN to add the saturating fault_count output.
module water_flow_supervisor
    import water_flow_pkg::*;
#(
    parameter int unsigned LEVEL_W    = 10,
    parameter int unsigned THRESHOLD  = 10,
    parameter int unsigned TIME_LIMIT = 10,
    parameter int unsigned LEVEL_HIGH = 950
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic               err_clear,
    output logic               error_flag,
    output logic [2:0]         error_code
`ifdef WFS_FAULT_COUNT_EN
    ,
    output logic [FaultCountW-1:0] fault_count
`endif
);

    // One extra bit so baseline+THRESHOLD never wraps.
    localparam logic [LEVEL_W:0] ThrExt  = (LEVEL_W + 1)'(THRESHOLD);
    localparam logic [LEVEL_W:0] HighExt = (LEVEL_W + 1)'(LEVEL_HIGH);

    state_e             state_q;
    logic [LEVEL_W-1:0] baseline_q;
    logic [1:0]         mode_q;

    logic [LEVEL_W:0] sensor_ext;
    logic [LEVEL_W:0] base_ext;
    logic             rise_ok;
    logic             fall_ok;
    logic             over_high;
    logic             monitoring;
    logic             progress;
    logic             fault_hit;
    logic [2:0]       fault_code;
    logic             expired;

    assign sensor_ext = {1'b0, water_level_sensor};
    assign base_ext   = {1'b0, baseline_q};
    assign rise_ok    = (sensor_ext >= base_ext + ThrExt);
    assign fall_ok    = (sensor_ext + ThrExt <= base_ext);
    assign over_high  = (sensor_ext >= HighExt);

    // A mode change or disable takes MONITOR elsewhere without any fault check.
    assign monitoring = (state_q == StMonitor) && enable && (mode != ModeIdle) && (mode == mode_q);

    always_comb begin
        progress   = 1'b0;
        fault_hit  = 1'b0;
        fault_code = ErrNone;
        if (monitoring) begin
            unique case (mode_q)
                ModeFill: begin
                    if (over_high) begin
                        fault_hit  = 1'b1;
                        fault_code = ErrOverflow;
                    end else if (fall_ok) begin
                        fault_hit  = 1'b1;
                        fault_code = ErrLeak;
                    end else if (rise_ok) begin
                        progress = 1'b1;
                    end else if (expired) begin
                        fault_hit  = 1'b1;
                        fault_code = ErrNoRise;
                    end
                end
                ModeDrain: begin
                    if (fall_ok || (water_level_sensor == '0)) begin
                        progress = 1'b1;
                    end else if (expired) begin
                        fault_hit  = 1'b1;
                        fault_code = ErrNoFall;
                    end
                end
                ModeHold: begin
                    if (rise_ok || fall_ok) begin
                        fault_hit  = 1'b1;
                        fault_code = ErrDrift;
                    end
                end
                default: ;
            endcase
        end
    end

    wfs_stall_timer #(
        .TIME_LIMIT (TIME_LIMIT)
    ) u_stall_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!monitoring || progress),
        .inc     (monitoring && !progress),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baseline_q <= '0;
            mode_q     <= ModeIdle;
            error_flag <= 1'b0;
            error_code <= ErrNone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable && (mode != ModeIdle)) begin
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (!enable || (mode == ModeIdle)) begin
                        state_q <= StIdle;
                    end else begin
                        baseline_q <= water_level_sensor;
                        mode_q     <= mode;
                        state_q    <= StMonitor;
                    end
                end
                StMonitor: begin
                    if (!enable || (mode == ModeIdle)) begin
                        state_q <= StIdle;
                    end else if (mode != mode_q) begin
                        state_q <= StArm;
                    end else if (fault_hit) begin
                        state_q    <= StFault;
                        error_flag <= 1'b1;
                        error_code <= fault_code;
                    end else if (progress) begin
                        baseline_q <= water_level_sensor;
                    end
                end
                StFault: begin
                    if (err_clear) begin
                        state_q    <= StIdle;
                        error_flag <= 1'b0;
                        error_code <= ErrNone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WFS_FAULT_COUNT_EN
    logic [FaultCountW-1:0] fault_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_count_q <= '0;
        end else if (fault_hit && (fault_count_q != '1)) begin
            fault_count_q <= fault_count_q + FaultCountW'(1);
        end
    end

    assign fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_water_flow_supervisor.sv
// Scoreboard bench: each driven cycle queues its expected outputs; a monitor compares after each edge.
module tb_water_flow_supervisor;

    localparam logic [1:0] MI = 2'b00;
    localparam logic [1:0] MF = 2'b01;
    localparam logic [1:0] MD = 2'b10;
    localparam logic [1:0] MH = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [9:0] water_level_sensor = '0;
    logic       err_clear = 1'b0;
    logic       error_flag;
    logic [2:0] error_code;
`ifdef WFS_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    typedef struct {
        logic       flag;
        logic [2:0] code;
        int         cnt;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    logic prev_flag = 1'b0;

    water_flow_supervisor #(
        .LEVEL_W    (10),
        .THRESHOLD  (10),
        .TIME_LIMIT (10),
        .LEVEL_HIGH (950)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .mode               (mode),
        .water_level_sensor (water_level_sensor),
        .err_clear          (err_clear),
        .error_flag         (error_flag),
        .error_code         (error_code)
`ifdef WFS_FAULT_COUNT_EN
        ,
        .fault_count        (fault_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: the outputs settle just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (error_flag !== e.flag || error_code !== e.code) begin
                    errors++;
                    $display("FAIL %s: got flag=%0b code=%03b, expected flag=%0b code=%03b",
                             e.tag, error_flag, error_code, e.flag, e.code);
                end
`ifdef WFS_FAULT_COUNT_EN
                checks++;
                if (fault_count !== 8'(e.cnt)) begin
                    errors++;
                    $display("FAIL %s count: got %0d, expected %0d", e.tag, fault_count, e.cnt);
                end
`endif
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [1:0] m, input int lvl,
                        input logic clr, input logic ef, input logic [2:0] ec, input string tag);
        exp_t e;
        @(negedge clk);
        reset              = r;
        enable             = en;
        mode               = m;
        water_level_sensor = 10'(lvl);
        err_clear          = clr;
        if (r) model_cnt = 0;
        else if (ef && !prev_flag) model_cnt++;
        prev_flag = ef;
        e.flag = ef;
        e.code = ec;
        e.cnt  = model_cnt;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic go(input logic [1:0] m, input int lvl, input logic ef, input logic [2:0] ec,
                      input string tag);
        step(1'b0, 1'b1, m, lvl, 1'b0, ef, ec, tag);
    endtask

    task automatic quiet(input logic [1:0] m, input int lvl, input int n, input string tag);
        for (int i = 0; i < n; i++) go(m, lvl, 1'b0, 3'b000, tag);
    endtask

    task automatic clear_fault(input string tag);
        step(1'b0, 1'b1, MI, 0, 1'b1, 1'b0, 3'b000, tag);
    endtask

    initial begin
        step(1'b1, 1'b0, MI, 0, 1'b0, 1'b0, 3'b000, "reset");
        step(1'b0, 1'b0, MI, 0, 1'b0, 1'b0, 3'b000, "idle");

        // Fill ramp 50..150 then stall: fault 10 edges after last progress.
        quiet(MF, 50, 2, "fill_arm");
        for (int l = 70; l <= 150; l += 20) go(MF, l, 1'b0, 3'b000, "fill_ramp");
        quiet(MF, 150, 9, "fill_stall");
        go(MF, 150, 1'b1, 3'b001, "no_rise");
        step(1'b0, 1'b0, MI, 150, 1'b0, 1'b1, 3'b001, "sticky_fault");
        clear_fault("clear_no_rise");

        // Drain ramp 200..100 then stall; err_clear while monitoring is ignored.
        quiet(MD, 200, 2, "drain_arm");
        for (int l = 180; l >= 100; l -= 20) go(MD, l, 1'b0, 3'b000, "drain_ramp");
        quiet(MD, 100, 4, "drain_stall");
        step(1'b0, 1'b1, MD, 100, 1'b1, 1'b0, 3'b000, "stray_clear");
        quiet(MD, 100, 4, "drain_stall");
        go(MD, 100, 1'b1, 3'b010, "no_fall");
        clear_fault("clear_no_fall");

        // Drain to empty and held empty never times out.
        quiet(MD, 30, 2, "empty_arm");
        go(MD, 10, 1'b0, 3'b000, "empty_ramp");
        quiet(MD, 0, 13, "empty_hold");
        go(MI, 0, 1'b0, 3'b000, "to_idle");

        // Slow fill +5/cycle progresses every second cycle.
        quiet(MF, 50, 2, "slow_arm");
        for (int l = 55; l <= 150; l += 5) go(MF, l, 1'b0, 3'b000, "slow_fill");
        go(MI, 150, 1'b0, 3'b000, "slow_idle");

        // Overflow jump, overflow boundary and leak.
        quiet(MF, 100, 2, "ovf_arm");
        go(MF, 960, 1'b1, 3'b011, "overflow_jump");
        clear_fault("clear_ovf");
        quiet(MF, 100, 2, "ovf_edge_arm");
        go(MF, 949, 1'b0, 3'b000, "below_high");
        go(MF, 950, 1'b1, 3'b011, "at_high");
        clear_fault("clear_ovf2");
        quiet(MF, 300, 2, "leak_arm");
        go(MF, 280, 1'b1, 3'b100, "leak");
        clear_fault("clear_leak");

        // Hold: small wobble and long stillness are fine, +12 drifts.
        quiet(MH, 300, 2, "hold_arm");
        go(MH, 309, 1'b0, 3'b000, "hold_wobble");
        quiet(MH, 305, 12, "hold_no_timeout");
        go(MH, 312, 1'b1, 3'b101, "drift_up");
        clear_fault("clear_drift");
        quiet(MH, 300, 2, "rearm");
        go(MH, 290, 1'b1, 3'b101, "drift_down");
        step(1'b1, 1'b1, MH, 300, 1'b1, 1'b0, 3'b000, "reset_with_clear");
        go(MH, 300, 1'b0, 3'b000, "post_reset_arm");
        go(MI, 300, 1'b0, 3'b000, "post_reset_idle");

        // Reset mid-MONITOR, then constant level faults exactly 10 edges into MONITOR.
        quiet(MF, 100, 7, "pre_reset_mon");
        step(1'b1, 1'b1, MF, 100, 1'b0, 1'b0, 3'b000, "reset_mid_mon");
        quiet(MF, 100, 11, "const_level");
        go(MF, 100, 1'b1, 3'b001, "const_timeout");
        clear_fault("clear_const");

        // Mode change on the edge the fill timer would expire re-baselines instead.
        quiet(MF, 100, 11, "mc_fill");
        go(MD, 100, 1'b0, 3'b000, "mode_change");
        quiet(MD, 100, 10, "mc_drain");
        go(MD, 100, 1'b1, 3'b010, "mc_no_fall");
        clear_fault("clear_mc");

        // Disable drops MONITOR to IDLE without faulting.
        quiet(MF, 100, 11, "dis_mon");
        step(1'b0, 1'b0, MF, 100, 1'b0, 1'b0, 3'b000, "disable");
        step(1'b0, 1'b0, MF, 100, 1'b0, 1'b0, 3'b000, "disabled");

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/water_flow_supervisor.md
WATER_FLOW_SUPERVISOR -- requirements
Module: water_flow_supervisor

Interface
REQ-001 The block SHALL have parameter LEVEL_W, default 10, giving the sensor width in bits.
REQ-002 The block SHALL have parameter THRESHOLD, default 10, giving the minimum level change that counts as progress.
REQ-003 The block SHALL have parameter TIME_LIMIT, default 10, giving the number of cycles allowed without progress.
REQ-004 The block SHALL have parameter LEVEL_HIGH, default 950, giving the fill overflow level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL sample on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit: monitoring is active when high.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 idle, 01 fill, 10 drain, 11 hold.
REQ-009 The block SHALL have port water_level_sensor, input, LEVEL_W bits: the unsigned level sample.
REQ-010 The block SHALL have port err_clear, input, 1 bit: a one-cycle pulse that acknowledges a fault.
REQ-011 The block SHALL have port error_flag, output, 1 bit: high while in FAULT.
REQ-012 The block SHALL have port error_code, output, 3 bits: 000 none, 001 NO_RISE, 010 NO_FALL, 011 OVERFLOW, 100 LEAK, 101 DRIFT.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, MONITOR and FAULT.
REQ-014 IDLE SHALL go to ARM when enable=1 and mode!=00.
REQ-015 ARM SHALL latch baseline<=sensor, clear the timer, and go to MONITOR after one cycle.
REQ-016 In fill mode, progress SHALL be sensor >= baseline+THRESHOLD; arithmetic SHALL be LEVEL_W+1 bits, with no wrap.
REQ-017 In drain mode, progress SHALL be sensor+THRESHOLD <= baseline (LEVEL_W+1 bits); sensor==0 SHALL count as progress.
REQ-018 On progress, the block SHALL set baseline<=sensor and timer<=0; otherwise timer SHALL increment, saturating.
REQ-019 No progress while timer==TIME_LIMIT-1 SHALL cause FAULT, with code NO_RISE in fill mode and NO_FALL in drain mode.
REQ-020 Fill with sensor >= LEVEL_HIGH SHALL cause FAULT OVERFLOW on the next edge; this check SHALL take priority over all other checks.
REQ-021 Fill with sensor+THRESHOLD <= baseline SHALL cause FAULT LEAK.
REQ-022 Hold mode with |sensor-baseline| >= THRESHOLD SHALL cause FAULT DRIFT; hold mode SHALL never raise a timeout.
REQ-023 A mode change during MONITOR SHALL go to ARM (re-baseline) and SHALL NOT fault in that cycle.
REQ-024 enable=0 or mode=00 SHALL force IDLE from ARM or MONITOR; FAULT SHALL be sticky regardless of enable.
REQ-025 FAULT SHALL leave only on err_clear, going to IDLE; err_clear outside FAULT SHALL have no effect.
REQ-026 error_flag and error_code SHALL be registered, updating on the same edge that enters or leaves FAULT; error_code SHALL read 000 outside FAULT.
REQ-027 With a constant level, the flag SHALL assert exactly TIME_LIMIT edges after entering MONITOR.

Reset
REQ-028 reset=1 SHALL, on the next clk edge, set state IDLE, baseline 0, timer 0, error_flag 0 and error_code 000.
REQ-029 Reset SHALL override err_clear, enable and any fault detected in the same cycle, including reset asserted mid-MONITOR.

Configuration
REQ-030 When WFS_FAULT_COUNT_EN is defined, the block SHALL add output fault_count (8 bits), which increments on each FAULT entry, saturates at 255, and clears on reset.
REQ-031 When WFS_FAULT_COUNT_EN is undefined, the fault_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Package water_flow_pkg SHALL hold the mode encoding, the state enum and the error_code constants.
REQ-033 Sub-module wfs_stall_timer SHALL hold the saturating no-progress counter (inputs clear and inc; output expired).

Verification (THRESHOLD=10, TIME_LIMIT=10, LEVEL_HIGH=950)
REQ-034 Fill, level 50 with +20 per cycle for 5 cycles, then held at 150 -> error_flag=0 during the ramp; then error_flag=1, code=001, 10 cycles after the last progress.
REQ-035 Drain, level 200 with -20 per cycle to 100, then held -> code=010 after 10 idle cycles; drain reaching 0 and held -> no fault.
REQ-036 Fill, level 50 with +5 per cycle for 20 cycles -> progress every 2 cycles and error_flag stays 0.
REQ-037 Fill, level jumps 100 to 960 -> code=011 on the next edge; fill drop 300 to 280 -> code=100.
REQ-038 Hold at 300, then 312 -> code=101; err_clear pulse -> flag 0 on the next edge, then re-arm; err_clear in the same cycle as reset -> reset values.
REQ-039 Reset asserted mid-MONITOR and a mode change 01 to 10 mid-MONITOR -> all outputs 0 next edge (reset case) and no spurious fault (mode-change case); with WFS_FAULT_COUNT_EN defined, fault_count increments per fault.
